// File: rtl/i2c_config_chain_seq.sv
// Ordered bring-up sequencer for a chain of I2C configuration engines: settle,
// launch, wait with timeout, bounded retry, and shared-SCL muxing of the active engine.
module i2c_config_chain_seq #(
  parameter int NUM_CH      = 3,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 50000,
  parameter int TIMEOUT_CYC = 2500000,
  parameter int MAX_RETRY   = 3,
  parameter int AUTO_START  = 1
) (
  input  logic              CLK_50,
  input  logic              RESET,
  input  logic              START,
  output logic [NUM_CH-1:0] CH_START,
  input  logic [NUM_CH-1:0] CH_DONE,
  input  logic [NUM_CH-1:0] CH_ERR,
  input  logic [NUM_CH-1:0] CH_SCL_IN,
  output logic              BUS_SCL,
  output logic [NUM_CH-1:0] RELEASE,
  output logic              ALL_RELEASE,
  output logic              BUSY,
  output logic              FAIL,
  output logic [CH_W-1:0]   FAIL_CH,
  output logic [7:0]        ATTEMPTS
);
  typedef enum logic [2:0] {
    S_IDLE, S_SETTLE, S_LAUNCH, S_WAIT, S_DONE, S_FAIL
  } state_t;

  localparam int unsigned CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
  localparam int unsigned CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYC - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [7:0]       RETRY_MAX    = 8'(MAX_RETRY);
  localparam logic [CH_W-1:0]  LAST_CH      = CH_W'(NUM_CH - 1);

  state_t            r_state, w_state;
  logic [CH_W-1:0]   r_ch, w_ch;
  logic [CNT_W-1:0]  r_cnt, w_cnt;
  logic [7:0]        r_retry, w_retry;
  logic [NUM_CH-1:0] r_release, w_release;
  logic [CH_W-1:0]   r_fail_ch, w_fail_ch;
  logic [7:0]        r_attempts, w_attempts;
  logic              r_first, w_first;
  logic              w_clear;
  logic              w_sel_done, w_sel_err, w_sel_scl;
  logic [NUM_CH-1:0] w_onehot;

  always_ff @(posedge CLK_50) begin
    if (RESET) begin
      r_state    <= S_IDLE;
      r_ch       <= '0;
      r_cnt      <= '0;
      r_retry    <= '0;
      r_release  <= '0;
      r_fail_ch  <= '0;
      r_attempts <= '0;
      r_first    <= 1'b1;
    end else begin
      r_state    <= w_state;
      r_ch       <= w_ch;
      r_cnt      <= w_cnt;
      r_retry    <= w_retry;
      r_release  <= w_release;
      r_fail_ch  <= w_fail_ch;
      r_attempts <= w_attempts;
      r_first    <= w_first;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_ch       = r_ch;
    w_cnt      = r_cnt;
    w_retry    = r_retry;
    w_release  = r_release;
    w_fail_ch  = r_fail_ch;
    w_attempts = r_attempts;
    w_first    = r_first;
    w_clear    = 1'b0;
    w_sel_done = 1'b0;
    w_sel_err  = 1'b0;
    w_sel_scl  = 1'b1;
    w_onehot   = '0;

    // Only the active channel's inputs are visible to the FSM.
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      if (r_ch == CH_W'(k)) begin
        w_onehot[k] = 1'b1;
        w_sel_done  = CH_DONE[k];
        w_sel_err   = CH_ERR[k];
        w_sel_scl   = CH_SCL_IN[k];
      end
    end

    case (r_state)
      S_IDLE: begin
        if (START || ((AUTO_START != 0) && r_first)) w_clear = 1'b1;
      end
      S_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_cnt   = '0;
          w_state = S_LAUNCH;
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_LAUNCH: begin
        if (r_attempts != 8'hFF) w_attempts = r_attempts + 8'd1;
        w_cnt   = '0;
        w_state = S_WAIT;
      end
      S_WAIT: begin
        if (w_sel_done) begin
          w_release = r_release | w_onehot;
          w_retry   = '0;
          w_cnt     = '0;
          if (r_ch == LAST_CH) begin
            w_state = S_DONE;
          end else begin
            w_ch    = r_ch + CH_W'(1);
            w_state = S_SETTLE;
          end
        end else if (w_sel_err || (r_cnt == TIMEOUT_LAST)) begin
          w_cnt = '0;
          if (r_retry < RETRY_MAX) begin
            w_retry = r_retry + 8'd1;
            w_state = S_SETTLE;
          end else begin
            w_fail_ch = r_ch;
            w_state   = S_FAIL;
          end
        end else begin
          w_cnt = r_cnt + CNT_W'(1);
        end
      end
      S_DONE, S_FAIL: begin
        if (START) w_clear = 1'b1;
      end
      default: w_state = S_IDLE;
    endcase

    if (w_clear) begin
      w_ch       = '0;
      w_cnt      = '0;
      w_retry    = '0;
      w_release  = '0;
      w_fail_ch  = '0;
      w_attempts = '0;
      w_first    = 1'b0;
      w_state    = S_SETTLE;
    end
  end

  assign CH_START    = (r_state == S_LAUNCH) ? w_onehot : '0;
  assign BUS_SCL     = ((r_state == S_LAUNCH) || (r_state == S_WAIT)) ? w_sel_scl : 1'b1;
  assign RELEASE     = r_release;
  assign ALL_RELEASE = (r_state == S_DONE);
  assign FAIL        = (r_state == S_FAIL);
  assign BUSY        = (r_state == S_SETTLE) || (r_state == S_LAUNCH) || (r_state == S_WAIT);
  assign FAIL_CH     = r_fail_ch;
  assign ATTEMPTS    = r_attempts;
endmodule

// File: tb/tb_i2c_config_chain_seq.sv
// Bench for i2c_config_chain_seq: table of scripted engine behaviours plus random
// plans, checked cycle by cycle against a timestamp-based model of the sequence.
module tb_i2c_config_chain_seq;
  localparam int NCH = 3;
  localparam int S   = 4;
  localparam int T   = 20;
  localparam int MR  = 2;
  localparam int NV  = 9;

  logic       clk = 1'b0;
  logic       rst, start;
  logic [2:0] ch_start, ch_done, ch_err, scl_in, rel;
  logic       bus_scl, all_rel, busy, fail_o;
  logic [1:0] fail_ch;
  logic [7:0] attempts;

  always #10 clk = ~clk;

  i2c_config_chain_seq #(
    .NUM_CH(NCH), .CH_W(2), .SETTLE_CYC(S), .TIMEOUT_CYC(T),
    .MAX_RETRY(MR), .AUTO_START(1)
  ) dut (
    .CLK_50(clk), .RESET(rst), .START(start), .CH_START(ch_start),
    .CH_DONE(ch_done), .CH_ERR(ch_err), .CH_SCL_IN(scl_in), .BUS_SCL(bus_scl),
    .RELEASE(rel), .ALL_RELEASE(all_rel), .BUSY(busy), .FAIL(fail_o),
    .FAIL_CH(fail_ch), .ATTEMPTS(attempts)
  );

  // Response kinds per (channel, attempt): 0 done, 1 err, 2 silent, 3 done+err.
  typedef struct packed {
    logic [8:0][1:0] kind;
    logic [8:0][4:0] dly;
    logic            noise;
    logic            scl1;
    logic [2:0]      e_rel;
    logic            e_fail;
    logic [1:0]      e_fch;
    logic [7:0]      e_att;
    logic            e_all;
  } vec_t;

  vec_t tbl [NV];
  int   p_kind [9];
  int   p_dly  [9];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Model results: launch cycles, channel, last WAIT cycle, release cycles.
  int m_lc[$], m_lch[$], m_we[$];
  int rel_c [NCH];
  int m_end, m_fail, m_fch, m_att;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic vec_t base();
    vec_t v;
    for (int j = 0; j < 9; j++) begin
      v.kind[j] = 2'd0;
      v.dly[j]  = 5'd3;
    end
    v.noise = 1'b0; v.scl1 = 1'b0;
    v.e_rel = 3'b111; v.e_fail = 1'b0; v.e_fch = 2'd0; v.e_att = 8'd3; v.e_all = 1'b1;
    return v;
  endfunction

  task automatic load_plan(input vec_t v);
    for (int j = 0; j < 9; j++) begin
      p_kind[j] = int'(v.kind[j]);
      p_dly[j]  = int'(v.dly[j]);
    end
  endtask

  // Sequence timeline derived from timestamps: SETTLE lasts S cycles, LAUNCH one,
  // a response d cycles after launch counts only if 1 <= d <= T.
  task automatic model(input int s0);
    int t, ch, rty, l, nx, idx, kd, dd;
    bit resp, fin;
    m_lc.delete(); m_lch.delete(); m_we.delete();
    for (int k = 0; k < NCH; k++) rel_c[k] = 1 << 30;
    m_att = 0; m_fail = 0; m_fch = 0; m_end = 0;
    t = s0; ch = 0; rty = 0; fin = 0;
    while (!fin) begin
      l = t + S;
      m_lc.push_back(l); m_lch.push_back(ch);
      if (m_att < 255) m_att++;
      idx = ch * 3 + rty; kd = p_kind[idx]; dd = p_dly[idx];
      resp = (kd != 2) && (dd >= 1) && (dd <= T);
      nx = resp ? l + dd + 1 : l + T + 1;
      m_we.push_back(nx - 1);
      if (resp && (kd == 0 || kd == 3)) begin
        rel_c[ch] = nx;
        if (ch == NCH - 1) begin m_end = nx; fin = 1; end
        else begin ch++; rty = 0; t = nx; end
      end else if (rty < MR) begin
        rty++; t = nx;
      end else begin
        m_fail = 1; m_fch = ch; m_end = nx; fin = 1;
      end
    end
  endtask

  task automatic run(input bit use_start, input bit noise, input bit scl1, input string tag);
    int att_c [NCH];
    int pend, pk, pc, idx, end_c;
    int bad_cs, bad_rel, bad_busy, bad_scl, ecs, erel, ebusy, escl;
    logic [2:0] cs;
    model(1);
    for (int k = 0; k < NCH; k++) att_c[k] = 0;
    pend = -1; pk = 0; pc = 0; end_c = -1;
    bad_cs = 0; bad_rel = 0; bad_busy = 0; bad_scl = 0;
    for (int cyc = 0; cyc <= 2000 && end_c < 0; cyc++) begin
      @(negedge clk);
      cs = ch_start;
      if (cyc >= 1) begin
        ecs = 0;
        for (int i = 0; i < m_lc.size(); i++) if (m_lc[i] == cyc) ecs = 1 << m_lch[i];
        if (cs !== 3'(ecs)) bad_cs++;
        erel = 0;
        for (int k = 0; k < NCH; k++) if (rel_c[k] <= cyc) erel |= 1 << k;
        if (rel !== 3'(erel)) bad_rel++;
        ebusy = (cyc < m_end) ? 1 : 0;
        if (int'(busy) != ebusy) bad_busy++;
      end
      ch_done = '0; ch_err = '0;
      for (int k = 0; k < NCH; k++) begin
        if (cs[k]) begin
          if (att_c[k] < 3) begin
            idx = k * 3 + att_c[k];
            if (p_kind[idx] != 2) begin pend = cyc + p_dly[idx]; pk = p_kind[idx]; pc = k; end
          end
          att_c[k]++;
        end
      end
      if (pend == cyc) begin
        if (pk == 0 || pk == 3) ch_done[pc] = 1'b1;
        if (pk == 1 || pk == 3) ch_err[pc]  = 1'b1;
        pend = -1;
      end
      if (noise && att_c[1] == 0) begin ch_done[2] = 1'b1; ch_err[1] = 1'b1; end
      scl_in = scl1 ? {1'b0, 1'($urandom), 1'b0} : 3'($urandom);
      start = use_start && (cyc == 0);
      if (!use_start && cyc == 0) rst = 1'b0;
      #1;
      if (cyc >= 1) begin
        escl = 1;
        for (int i = 0; i < m_lc.size(); i++)
          if (cyc >= m_lc[i] && cyc <= m_we[i]) escl = int'(scl_in[m_lch[i]]);
        if (int'(bus_scl) != escl) bad_scl++;
        if (all_rel || fail_o) end_c = cyc;
      end
    end
    ch_done = '0; ch_err = '0; start = 1'b0;
    check({tag, "_ch_start_trace"}, bad_cs, 0);
    check({tag, "_release_trace"}, bad_rel, 0);
    check({tag, "_busy_trace"}, bad_busy, 0);
    check({tag, "_bus_scl_trace"}, bad_scl, 0);
    check({tag, "_end_cycle"}, end_c, m_end);
  endtask

  task automatic check_final(input string tag, input int e_rel, input int e_fail,
                             input int e_fch, input int e_att, input int e_all);
    check({tag, "_release"}, int'(rel), e_rel);
    check({tag, "_fail"}, int'(fail_o), e_fail);
    check({tag, "_fail_ch"}, int'(fail_ch), e_fch);
    check({tag, "_attempts"}, int'(attempts), e_att);
    check({tag, "_all_release"}, int'(all_rel), e_all);
    check({tag, "_bus_scl_idle"}, int'(bus_scl), 1);
    check({tag, "_busy_idle"}, int'(busy), 0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_ch_start"}, int'(ch_start), 0);
    check({tag, "_bus_scl"}, int'(bus_scl), 1);
    check({tag, "_release"}, int'(rel), 0);
    check({tag, "_all_release"}, int'(all_rel), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_fail"}, int'(fail_o), 0);
    check({tag, "_fail_ch"}, int'(fail_ch), 0);
    check({tag, "_attempts"}, int'(attempts), 0);
  endtask

  initial begin
    int erel, bad;
    rst = 1'b1; start = 1'b0; ch_done = '0; ch_err = '0; scl_in = '0;

    tbl[0] = base();                                                    // nominal, auto-start
    tbl[1] = base(); tbl[1].kind[3] = 2'd1; tbl[1].dly[3] = 5'd2;       // ch1 err, err, done
    tbl[1].kind[4] = 2'd1; tbl[1].dly[4] = 5'd2; tbl[1].e_att = 8'd5;
    tbl[2] = base(); tbl[2].kind[6] = 2'd2; tbl[2].kind[7] = 2'd2;      // ch2 silent
    tbl[2].kind[8] = 2'd2; tbl[2].e_rel = 3'b011; tbl[2].e_fail = 1'b1;
    tbl[2].e_fch = 2'd2; tbl[2].e_att = 8'd5; tbl[2].e_all = 1'b0;
    tbl[3] = base(); tbl[3].kind[0] = 2'd3; tbl[3].dly[0] = 5'd2;       // restart after fail
    tbl[3].noise = 1'b1;
    tbl[4] = base(); tbl[4].scl1 = 1'b1;                                // only ch1 SCL toggles
    tbl[5] = base(); tbl[5].dly[0] = 5'd0; tbl[5].e_att = 8'd4;         // done in launch cycle
    tbl[6] = base(); tbl[6].dly[0] = 5'(T);                             // done on last WAIT cycle
    tbl[7] = base(); tbl[7].dly[2] = 5'd1;
    for (int j = 0; j < 3; j++) begin tbl[7].kind[j] = 2'd1; tbl[7].dly[j] = 5'd1; end
    tbl[7].e_rel = 3'b000; tbl[7].e_fail = 1'b1; tbl[7].e_att = 8'd3; tbl[7].e_all = 1'b0;
    tbl[8] = base(); tbl[8].kind[2] = 2'd1;                             // error on first WAIT cycle
    tbl[8].kind[0] = 2'd1; tbl[8].dly[0] = 5'd1; tbl[8].e_att = 8'd4;

    repeat (3) @(negedge clk);
    check_reset("por");

    for (int i = 0; i < NV; i++) begin
      string tag;
      tag = $sformatf("vec%0d", i);
      load_plan(tbl[i]);
      run(i != 0, tbl[i].noise, tbl[i].scl1, tag);
      check_final(tag, int'(tbl[i].e_rel), int'(tbl[i].e_fail), int'(tbl[i].e_fch),
                  int'(tbl[i].e_att), int'(tbl[i].e_all));
    end

    for (int r = 0; r < 8; r++) begin
      string tag;
      int x;
      tag = $sformatf("rnd%0d", r);
      for (int j = 0; j < 9; j++) begin
        x = $urandom_range(0, 5);
        p_kind[j] = (x <= 2) ? 0 : (x == 3) ? 1 : (x == 4) ? 2 : 3;
        p_dly[j]  = $urandom_range(0, T);
      end
      run(1'b1, 1'b0, 1'b0, tag);
      erel = 0;
      for (int k = 0; k < NCH; k++) if (rel_c[k] <= m_end) erel |= 1 << k;
      check_final(tag, erel, m_fail, m_fch, m_att, 1 - m_fail);
    end

    // Reset in the middle of a WAIT with a silent engine.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 50 && ch_start == 3'b000; i++) @(negedge clk);
    check("rmw_launch_seen", int'(ch_start), 1);
    repeat (3) @(negedge clk);
    check("rmw_in_wait_busy", int'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    check_reset("rmw");
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (ch_start != 3'b000) bad++;
    end
    check("rmw_hold_ch_start", bad, 0);
    load_plan(base());
    run(1'b0, 1'b0, 1'b0, "post_rst");
    check_final("post_rst", 7, 0, 0, 3, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/i2c_config_chain_seq.md
# i2c_config_chain_seq

Parametrised sequencer that brings up a chain of NUM_CH I2C configuration engines (VCM, sensor, MIPI bridge and later additions) strictly in order, each channel starting only after the previous one has released. It adds settle delays, per-channel timeout, bounded retry and failure reporting. It muxes the active engine's SCL onto a shared bus. It sits between board reset and the per-device config engines in the camera front-end.

## Interface
- NUM_CH, 3: number of chained channels (1..8); channel 0 runs first
- CH_W, 2: width of channel index (>= clog2(NUM_CH), min 1)
- SETTLE_CYC, 50000: idle cycles before each launch, including retries (1 ms at 50 MHz); min 1
- TIMEOUT_CYC, 2500000: max cycles in WAIT per attempt; min 2
- MAX_RETRY, 3: retries per channel after the first attempt (0 = no retry)
- AUTO_START, 1: 1 = sequence starts after reset without START

Ports:
- CLK_50  in  1  system clock
- RESET  in  1  synchronous, active-high reset
- START  in  1  level; starts or restarts the sequence when not busy
- CH_START  out  NUM_CH  one-cycle launch pulse to channel engine
- CH_DONE  in  NUM_CH  engine finished OK (pulse or level)
- CH_ERR  in  NUM_CH  engine NACK/abort (pulse or level)
- CH_SCL_IN  in  NUM_CH  per-engine SCL
- BUS_SCL  out  1  shared SCL
- RELEASE  out  NUM_CH  sticky per-channel success
- ALL_RELEASE  out  1  all channels released
- BUSY  out  1  state is not IDLE/DONE/FAIL
- FAIL  out  1  sticky sequence failure
- FAIL_CH  out  CH_W  channel that failed
- ATTEMPTS  out  8  total launches since start, saturating at 255

## Operation
- States: IDLE, SETTLE, LAUNCH, WAIT, DONE, FAIL. Registers: ch index, settle/timeout counter, retry count (per channel).
- IDLE: if AUTO_START=1 and this is the first IDLE after reset, or if START=1, clear ch, retry count, RELEASE, FAIL, FAIL_CH and ATTEMPTS, then go to SETTLE.
- SETTLE: count SETTLE_CYC cycles, then go to LAUNCH.
- LAUNCH (1 cycle): CH_START[ch]=1. ATTEMPTS increments, saturating. Clear the counter. Go to WAIT.
- WAIT: samples only CH_DONE[ch] and CH_ERR[ch]. Inputs from other channels are ignored.
  - CH_DONE[ch]=1: set RELEASE[ch] and clear retry count. If ch==NUM_CH-1, go to DONE. Else ch+1 and go to SETTLE.
  - CH_ERR[ch]=1, or counter reaches TIMEOUT_CYC-1 without DONE: if retry count < MAX_RETRY, increment it and go to SETTLE with the same ch. Else go to FAIL and set FAIL_CH=ch.
  - DONE and ERR on the same cycle: DONE wins.
- DONE: ALL_RELEASE=1. START=1 restarts by taking the IDLE clear path and going to SETTLE.
- FAIL: FAIL=1. RELEASE bits of earlier channels are kept. START=1 restarts the same way.
- START is ignored while BUSY.
- BUS_SCL = CH_SCL_IN[ch] in LAUNCH and WAIT; 1 otherwise (bus idle).
- RELEASE[k] never deasserts except on RESET or restart, so downstream engines can chain directly on it.

## Timing
- Reset values: CH_START=0, BUS_SCL=1, RELEASE=0, ALL_RELEASE=0, BUSY=0, FAIL=0, FAIL_CH=0, ATTEMPTS=0. State is IDLE.
- RESET is honoured in any state on the next edge. CH_START is never 1 in the cycle after a RESET-high edge.
- AUTO_START: first CLK_50 edge with RESET=0 moves IDLE to SETTLE. The CH_START[0] pulse follows SETTLE_CYC+1 edges later.
- Registered outputs: RELEASE[ch] rises one cycle after CH_DONE[ch] is sampled. ALL_RELEASE and FAIL rise on the DONE/FAIL entry edge.
- Minimum per-channel latency, with DONE on the first WAIT cycle: SETTLE_CYC+2 cycles.
- Timeout: FAIL or retry is taken exactly TIMEOUT_CYC cycles after entering WAIT.
- CH_DONE or CH_ERR asserted in the LAUNCH cycle is ignored. Level-high done from a previous attempt is only counted in WAIT.

## Test plan
- Nominal, with NUM_CH=3, SETTLE_CYC=4, TIMEOUT_CYC=20, MAX_RETRY=2. Stimulus: engines assert DONE 3 cycles after CH_START. Required: CH_START pulses on channels 0, 1, 2 in order, RELEASE goes 001→011→111, ALL_RELEASE=1, ATTEMPTS=3, FAIL=0.
- Retry recovery. Stimulus: channel 1 asserts ERR on its first two attempts, then DONE. Required: three CH_START[1] pulses each preceded by 4 settle cycles, final RELEASE=111, ATTEMPTS=5.
- Timeout fail. Stimulus: channel 2 never responds. Required: 3 launches of channel 2, each timed out at exactly 20 cycles, then FAIL=1, FAIL_CH=2, RELEASE=011, ALL_RELEASE=0, BUS_SCL=1.
- Simultaneous and foreign events. Stimulus: DONE+ERR on the same cycle for ch 0; DONE on ch 2 while ch 0 is active. Required: ch 0 released with no retry; ch 2's early DONE is ignored.
- Restart and reset. Stimulus: START after FAIL. Required: RELEASE clears and CH_START[0] follows after settle. Stimulus: RESET mid-WAIT. Required: all outputs return to reset values on the next edge, and CH_START stays 0 during RESET.
- SCL mux. Stimulus: toggle CH_SCL_IN[1] only. Required: BUS_SCL follows it only while ch 1 is in LAUNCH/WAIT, and is 1 otherwise.
